// File: rtl/int_pkg.sv
// Shared parameters and FSM encoding for the nested interrupt scheduler.
package int_pkg;

  localparam int          NSRC_DEF      = 3;
  localparam int          ID_W_DEF      = 2;
  localparam logic [31:0] VEC_BASE_DEF  = 32'h0000_0100;
  localparam int          VEC_SHIFT_DEF = 4;

  // Request FSM: HOLD is a one-cycle gap after an ack so the CPU's IE clear can land.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/int_scheduler_if.sv
// Bundle of source, CP0 and pipeline-handshake signals around the interrupt scheduler.
interface int_scheduler_if import int_pkg::*; #(
  parameter int NSRC = NSRC_DEF,
  parameter int ID_W = ID_W_DEF
) ();

  logic [NSRC-1:0] intsrc;
  logic            ie;
  logic            mask_we;
  logic [NSRC-1:0] mask_din;
  logic            irq;
  logic            irq_ack;
  logic            eret;
  logic [31:0]     vector;
  logic [ID_W-1:0] svc_id;
  logic            svc_active;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;

  // CPU / environment side
  modport master (
    output intsrc, ie, mask_we, mask_din, irq_ack, eret,
    input  irq, vector, svc_id, svc_active, pending, mask
  );

  // Scheduler side
  modport slave (
    input  intsrc, ie, mask_we, mask_din, irq_ack, eret,
    output irq, vector, svc_id, svc_active, pending, mask
  );

endinterface

// File: rtl/int_prio_enc.sv
// Priority encoder: index of the highest set bit plus a non-empty flag.
module int_prio_enc #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan upwards so the highest set bit overwrites any lower one.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/int_scheduler.sv
// Nested prioritised interrupt scheduler: edge capture, masking, in-service
// stack with strict pre-emption, irq/ack handshake and vector generation.
module int_scheduler import int_pkg::*; #(
  parameter int          NSRC      = NSRC_DEF,
  parameter int          ID_W      = ID_W_DEF,
  parameter logic [31:0] VEC_BASE  = VEC_BASE_DEF,
  parameter int          VEC_SHIFT = VEC_SHIFT_DEF
) (
  input logic            clk,
  input logic            rst,
  int_scheduler_if.slave bus
);

  logic [NSRC-1:0] prev_r, pending_r, mask_r, svc_r;
  logic [NSRC-1:0] edge_s, elig_s, clr_s, pend_next_s, svc_next_s;
  state_t          state_r, state_next_s;
  logic            irq_r, svc_active_r;
  logic [31:0]     vector_r;
  logic [ID_W-1:0] svc_id_r, cand_id_s, top_next_id_s;
  logic            cand_v_s, top_next_v_s, cand_ok_s, ack_fire_s;

  assign edge_s      = bus.intsrc & ~prev_r;
  assign elig_s      = pending_r & mask_r;
  // A fresh edge in the ack cycle re-arms the bit being cleared.
  assign pend_next_s = (pending_r & ~clr_s) | edge_s;

  int_prio_enc #(.N(NSRC), .W(ID_W)) u_cand_enc (
    .vec   (elig_s),
    .idx   (cand_id_s),
    .valid (cand_v_s)
  );

  // Top of the post-update in-service set feeds the registered svc_id/svc_active.
  int_prio_enc #(.N(NSRC), .W(ID_W)) u_top_enc (
    .vec   (svc_next_s),
    .idx   (top_next_id_s),
    .valid (top_next_v_s)
  );

  // Candidate is eligible only if strictly above the current in-service level.
  always_comb begin
    cand_ok_s = 1'b0;
    if (bus.ie && cand_v_s) begin
      if (!svc_active_r) begin
        cand_ok_s = 1'b1;
      end else if (cand_id_s > svc_id_r) begin
        cand_ok_s = 1'b1;
      end else begin
        cand_ok_s = 1'b0;
      end
    end else begin
      cand_ok_s = 1'b0;
    end
  end

  // Request FSM next state; an ack is taken only while the candidate is still eligible.
  always_comb begin
    state_next_s = state_r;
    ack_fire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cand_ok_s) begin
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack && cand_ok_s) begin
          ack_fire_s   = 1'b1;
          state_next_s = ST_HOLD;
        end else if (!cand_ok_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_HOLD: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // In-service update: eret pops the old top, then an ack pushes the new source.
  always_comb begin
    svc_next_s = svc_r;
    clr_s      = {NSRC{1'b0}};
    if (bus.eret && svc_active_r) begin
      svc_next_s[svc_id_r] = 1'b0;
    end else begin
      svc_next_s = svc_r;
    end
    if (ack_fire_s) begin
      svc_next_s[cand_id_s] = 1'b1;
      clr_s[cand_id_s]      = 1'b1;
    end else begin
      clr_s = {NSRC{1'b0}};
    end
  end

  // Edge history, pending bits and software mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r    <= {NSRC{1'b0}};
      pending_r <= {NSRC{1'b0}};
      mask_r    <= {NSRC{1'b0}};
    end else begin
      prev_r    <= bus.intsrc;
      pending_r <= pend_next_s;
      if (bus.mask_we) begin
        mask_r <= bus.mask_din;
      end
    end
  end

  // FSM state, irq output, in-service set and vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      irq_r        <= 1'b0;
      svc_r        <= {NSRC{1'b0}};
      svc_id_r     <= {ID_W{1'b0}};
      svc_active_r <= 1'b0;
      vector_r     <= VEC_BASE;
    end else begin
      state_r      <= state_next_s;
      irq_r        <= (state_next_s == ST_REQ);
      svc_r        <= svc_next_s;
      svc_id_r     <= top_next_id_s;
      svc_active_r <= top_next_v_s;
      if (ack_fire_s) begin
        vector_r <= VEC_BASE + (32'(cand_id_s) << VEC_SHIFT);
      end
    end
  end

  assign bus.irq        = irq_r;
  assign bus.vector     = vector_r;
  assign bus.svc_id     = svc_id_r;
  assign bus.svc_active = svc_active_r;
  assign bus.pending    = pending_r;
  assign bus.mask       = mask_r;

endmodule

// File: tb/tb_int_scheduler.sv
// Directed bench for int_scheduler: stimulus queues expected ack results,
// a monitor compares them when the DUT takes an ack; level checks are inline.
module tb_int_scheduler;
  import int_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_scheduler_if #(.NSRC(3), .ID_W(2)) bif ();

  int_scheduler #(
    .NSRC(3), .ID_W(2), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [31:0] vector;
    logic [1:0]  svc_id;
    logic        svc_active;
    logic [2:0]  pending;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack(input logic [31:0] v, input logic [1:0] id, input logic [2:0] pend);
    exp_t e;
    e.vector     = v;
    e.svc_id     = id;
    e.svc_active = 1'b1;
    e.pending    = pend;
    sb_q.push_back(e);
    bif.irq_ack = 1'b1;
    tick();
    bif.irq_ack = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_irq"},     32'(bif.irq),        32'd0);
    chk({tag, "_vector"},  bif.vector,          32'h0000_0100);
    chk({tag, "_svc_id"},  32'(bif.svc_id),     32'd0);
    chk({tag, "_active"},  32'(bif.svc_active), 32'd0);
    chk({tag, "_pending"}, 32'(bif.pending),    32'd0);
    chk({tag, "_mask"},    32'(bif.mask),       32'd0);
  endtask

  // Monitor: an ack seen while irq is high is checked one edge later against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bif.irq && bif.irq_ack && !rst) begin
        @(posedge clk);
        #2;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got vector=%h with no expected entry", bif.vector);
        end else begin
          e = sb_q.pop_front();
          chk("ack_vector",  bif.vector,          e.vector);
          chk("ack_svc_id",  32'(bif.svc_id),     32'(e.svc_id));
          chk("ack_active",  32'(bif.svc_active), 32'(e.svc_active));
          chk("ack_pending", 32'(bif.pending),    32'(e.pending));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bif.intsrc   = 3'b000;
    bif.ie       = 1'b0;
    bif.mask_we  = 1'b0;
    bif.mask_din = 3'b000;
    bif.irq_ack  = 1'b0;
    bif.eret     = 1'b0;
    tick(2);
    chk_reset("rst0");
    rst = 1'b0;

    // S1: single source 1 through to ack
    bif.ie = 1'b1; bif.mask_we = 1'b1; bif.mask_din = 3'b111;
    tick();
    bif.mask_we = 1'b0;
    chk("s1_mask", 32'(bif.mask), 32'd7);
    bif.intsrc = 3'b010;
    tick();
    chk("s1_pending", 32'(bif.pending), 32'd2);
    chk("s1_irq_lat", 32'(bif.irq), 32'd0);
    tick();
    chk("s1_irq", 32'(bif.irq), 32'd1);
    bif.intsrc = 3'b000;
    ack(32'h0000_0110, 2'd1, 3'b000);
    chk("s1_hold_irq", 32'(bif.irq), 32'd0);

    // S2: lower source blocked, higher source nests, eret unwinds
    bif.intsrc = 3'b001;
    tick();
    bif.intsrc = 3'b000;
    tick();
    chk("s2_pend0", 32'(bif.pending), 32'd1);
    chk("s2_noirq", 32'(bif.irq), 32'd0);
    bif.intsrc = 3'b100;
    tick();
    bif.intsrc = 3'b000;
    tick();
    chk("s2_irq2", 32'(bif.irq), 32'd1);
    ack(32'h0000_0120, 2'd2, 3'b001);
    tick();
    chk("s2_nested_idle", 32'(bif.irq), 32'd0);
    bif.eret = 1'b1;
    tick();
    bif.eret = 1'b0;
    chk("s2_eret1_id", 32'(bif.svc_id), 32'd1);
    chk("s2_eret1_active", 32'(bif.svc_active), 32'd1);
    chk("s2_eret1_irq", 32'(bif.irq), 32'd0);
    bif.ie = 1'b0; bif.eret = 1'b1;
    tick();
    bif.eret = 1'b0;
    chk("s2_eret2_active", 32'(bif.svc_active), 32'd0);
    tick();
    chk("s2_ie_off", 32'(bif.irq), 32'd0);
    bif.ie = 1'b1;
    tick();
    chk("s2_src0_irq", 32'(bif.irq), 32'd1);

    // S3: higher source arrives during REQ for source 0 and wins the ack
    bif.intsrc = 3'b100;
    tick();
    bif.intsrc = 3'b000;
    ack(32'h0000_0120, 2'd2, 3'b001);
    tick();
    chk("s3_idle", 32'(bif.irq), 32'd0);
    tick();
    chk("s3_blocked", 32'(bif.irq), 32'd0);
    bif.eret = 1'b1;
    tick();
    bif.eret = 1'b0;
    chk("s3_after_eret", 32'(bif.irq), 32'd0);
    tick();
    chk("s3_resume", 32'(bif.irq), 32'd1);

    // S4: ie drop in REQ withdraws the request without losing pending
    bif.ie = 1'b0;
    tick();
    chk("s4_ie_drop", 32'(bif.irq), 32'd0);
    chk("s4_pend", 32'(bif.pending), 32'd1);
    bif.ie = 1'b1;
    tick();
    chk("s4_reassert", 32'(bif.irq), 32'd1);
    ack(32'h0000_0100, 2'd0, 3'b000);
    tick();
    bif.eret = 1'b1;
    tick();
    bif.eret = 1'b0;
    chk("s4_empty", 32'(bif.svc_active), 32'd0);

    // S5: masked sources stay pending; unmasking source 2 raises irq
    bif.mask_we = 1'b1; bif.mask_din = 3'b000;
    tick();
    bif.mask_we = 1'b0;
    chk("s5_mask0", 32'(bif.mask), 32'd0);
    bif.intsrc = 3'b111;
    tick();
    bif.intsrc = 3'b000;
    tick();
    chk("s5_pend_all", 32'(bif.pending), 32'd7);
    chk("s5_noirq", 32'(bif.irq), 32'd0);
    bif.mask_we = 1'b1; bif.mask_din = 3'b100;
    tick();
    bif.mask_we = 1'b0;
    chk("s5_irq_lat", 32'(bif.irq), 32'd0);
    tick();
    chk("s5_irq", 32'(bif.irq), 32'd1);
    ack(32'h0000_0120, 2'd2, 3'b011);
    tick();
    chk("s5_idle", 32'(bif.irq), 32'd0);
    bif.eret = 1'b1;
    tick();
    bif.eret = 1'b0;
    tick();
    chk("s5_masked", 32'(bif.irq), 32'd0);
    chk("s5_empty", 32'(bif.svc_active), 32'd0);

    // S6: new edge on source 1 in its own ack cycle keeps pending[1]
    bif.mask_we = 1'b1; bif.mask_din = 3'b111;
    tick();
    bif.mask_we = 1'b0;
    tick();
    chk("s6_irq", 32'(bif.irq), 32'd1);
    bif.intsrc = 3'b010;
    ack(32'h0000_0110, 2'd1, 3'b011);
    bif.intsrc = 3'b000;
    tick();
    chk("s6_blocked", 32'(bif.irq), 32'd0);
    bif.eret = 1'b1;
    tick();
    bif.eret = 1'b0;
    tick();
    chk("s6_req_again", 32'(bif.irq), 32'd1);

    // S7: reset in the middle of REQ
    rst = 1'b1;
    tick();
    chk_reset("rst_req");
    rst = 1'b0;

    tick(2);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
